// File: rtl/sll_64b_pipe_if.sv
// Operation bus for the 64-bit pipelined left shifter/rotator.
// The master issues operations on init_i and collects results on done_o.
interface sll_64b_pipe_if;
    localparam int unsigned W = 64;

    logic         init_i;
    logic         rotate_i;
    logic [W-1:0] shift_i;
    logic [W-1:0] data_i;
    logic         done_o;
    logic [W-1:0] data_o;

    modport master (
        output init_i, rotate_i, shift_i, data_i,
        input  done_o, data_o
    );

    modport slave (
        input  init_i, rotate_i, shift_i, data_i,
        output done_o, data_o
    );
endinterface

// File: rtl/sll_64b_pipe.sv
// 64-bit pipelined logical-left shifter / left rotator with a one-hot amount.
// Pipeline registers are placed after the encoder, any barrel stage and the output.
module sll_64b_pipe #(
    parameter bit       ENC_REG    = 1'b1,
    parameter bit [5:0] STAGE_MASK = 6'b001001,
    parameter bit       OUT_REG    = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    sll_64b_pipe_if.slave bus
);
    localparam int unsigned W    = 64;
    localparam int unsigned AW   = 6;
    localparam int unsigned NSTG = 6;

    // Highest set bit of the one-hot amount wins; all-zero means no shift.
    function automatic logic [AW-1:0] encode(input logic [W-1:0] s);
        logic [AW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            if (s[i]) n = AW'(i);
        end
        return n;
    endfunction

    function automatic logic [W-1:0] stage_shift(input logic [W-1:0] d, input logic rot,
                                                 input int k);
        int unsigned sh;
        sh = 32'd1 << k;
        if (rot) return (d << sh) | (d >> (W - sh));
        return d << sh;
    endfunction

    logic          e_vld_d, e_vld_q;
    logic          e_rot_d, e_rot_q;
    logic [AW-1:0] e_amt_d, e_amt_q;
    logic [W-1:0]  e_dat_d, e_dat_q;

    logic          s_vld_d [NSTG];
    logic          s_vld_q [NSTG];
    logic          s_rot_d [NSTG];
    logic          s_rot_q [NSTG];
    logic [AW-1:0] s_amt_d [NSTG];
    logic [AW-1:0] s_amt_q [NSTG];
    logic [W-1:0]  s_dat_d [NSTG];
    logic [W-1:0]  s_dat_q [NSTG];

    logic          c_vld;
    logic          c_rot;
    logic [AW-1:0] c_amt;
    logic [W-1:0]  c_dat;

    logic          done_q;
    logic [W-1:0]  data_q;

    assign e_vld_d = bus.init_i;
    assign e_rot_d = bus.rotate_i;
    assign e_amt_d = encode(bus.shift_i);
    assign e_dat_d = bus.data_i;

    // Walk the barrel; each stage either feeds forward combinationally or via its register.
    always_comb begin
        if (ENC_REG) begin
            c_vld = e_vld_q;
            c_rot = e_rot_q;
            c_amt = e_amt_q;
            c_dat = e_dat_q;
        end else begin
            c_vld = e_vld_d;
            c_rot = e_rot_d;
            c_amt = e_amt_d;
            c_dat = e_dat_d;
        end
        for (int k = 0; k < NSTG; k++) begin
            s_vld_d[k] = c_vld;
            s_rot_d[k] = c_rot;
            s_amt_d[k] = c_amt;
            s_dat_d[k] = c_amt[k] ? stage_shift(c_dat, c_rot, k) : c_dat;
            if (STAGE_MASK[k]) begin
                c_vld = s_vld_q[k];
                c_rot = s_rot_q[k];
                c_amt = s_amt_q[k];
                c_dat = s_dat_q[k];
            end else begin
                c_vld = s_vld_d[k];
                c_rot = s_rot_d[k];
                c_amt = s_amt_d[k];
                c_dat = s_dat_d[k];
            end
        end
    end

    // Data registers load every cycle; only the valid bits sequence operations.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e_vld_q <= 1'b0;
            e_rot_q <= 1'b0;
            e_amt_q <= '0;
            e_dat_q <= '0;
            for (int k = 0; k < NSTG; k++) begin
                s_vld_q[k] <= 1'b0;
                s_rot_q[k] <= 1'b0;
                s_amt_q[k] <= '0;
                s_dat_q[k] <= '0;
            end
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            e_vld_q <= e_vld_d;
            e_rot_q <= e_rot_d;
            e_amt_q <= e_amt_d;
            e_dat_q <= e_dat_d;
            for (int k = 0; k < NSTG; k++) begin
                s_vld_q[k] <= s_vld_d[k];
                s_rot_q[k] <= s_rot_d[k];
                s_amt_q[k] <= s_amt_d[k];
                s_dat_q[k] <= s_dat_d[k];
            end
            done_q <= c_vld;
            data_q <= c_vld ? c_dat : '0;
        end
    end

    // Unregistered output is gated by reset so nothing leaks while rst_n_i is low.
    assign bus.done_o = OUT_REG ? done_q : (rst_n_i & c_vld);
    assign bus.data_o = OUT_REG ? data_q : ((rst_n_i & c_vld) ? c_dat : '0);
endmodule

// File: tb/tb_sll_64b_pipe.sv
// Scoreboard bench for sll_64b_pipe: one shared stimulus stream drives a sweep of
// pipeline configurations, each checked for result, latency and order against a model.
module tb_sll_64b_pipe;
    localparam int NCFG = 13;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic        rot;
    logic [63:0] shift;
    logic [63:0] data;
    int          cyc;
    bit          fin;
    int          checks;
    int          errors;

    typedef struct {
        logic [63:0] d;
        int          c;
    } ent_t;

    function automatic int pc6(input bit [5:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) n += int'(m[i]);
        return n;
    endfunction

    // Reference: amount = highest set bit; rotate taken from the top half of {d,d} << n.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [63:0] s,
                                              input logic r);
        int           n;
        logic [127:0] w;
        n = 0;
        for (int i = 63; i >= 0; i--) begin
            if (s[i]) begin
                n = i;
                break;
            end
        end
        w = {d, d} << n;
        return r ? w[127:64] : (d << n);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
        localparam bit [5:0] M = (g < 4) ? 6'h00 : (g < 8) ? 6'h3F : (g < 12) ? 6'h15 : 6'h09;
        localparam bit       E = (g == 12) ? 1'b1 : 1'(g % 2);
        localparam bit       O = (g == 12) ? 1'b1 : 1'((g / 2) % 2);
        localparam int       L = int'(E) + int'(O) + pc6(M);

        sll_64b_pipe_if bus ();
        ent_t q[$];
        ent_t e;
        bit   fin_done;

        assign bus.init_i   = init;
        assign bus.rotate_i = rot;
        assign bus.shift_i  = shift;
        assign bus.data_i   = data;

        sll_64b_pipe #(.ENC_REG(E), .STAGE_MASK(M), .OUT_REG(O)) dut (
            .clk_i  (clk),
            .rst_n_i(rst_n),
            .bus    (bus.slave)
        );

        always @(negedge clk) begin
            if (rst_n !== 1'b1) begin
                q.delete();
                checks++;
                if (bus.done_o !== 1'b0 || bus.data_o !== 64'h0) begin
                    errors++;
                    $display("FAIL reset_out cfg%0d: done=%b data=%h, required done=0 data=0",
                             g, bus.done_o, bus.data_o);
                end
            end else begin
                if (init === 1'b1) q.push_back('{ref_shift(data, shift, rot), cyc});
                checks++;
                if (bus.done_o === 1'b1) begin
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_done cfg%0d: done=1 data=%h at cycle %0d, required no op in flight",
                                 g, bus.data_o, cyc);
                    end else begin
                        e = q.pop_front();
                        if (bus.data_o !== e.d || (cyc - e.c) != L) begin
                            errors++;
                            $display("FAIL result cfg%0d: data=%h latency=%0d, required data=%h latency=%0d",
                                     g, bus.data_o, cyc - e.c, e.d, L);
                        end
                    end
                end else if (bus.done_o !== 1'b0 || bus.data_o !== 64'h0) begin
                    errors++;
                    $display("FAIL idle_out cfg%0d: done=%b data=%h, required done=0 data=0",
                             g, bus.done_o, bus.data_o);
                end
            end
            if (fin && !fin_done) begin
                fin_done = 1'b1;
                checks++;
                if (q.size() != 0) begin
                    errors++;
                    $display("FAIL lost_ops cfg%0d: %0d ops never completed, required 0", g, q.size());
                end
            end
        end
    end

    task automatic drive(input logic v, input logic r, input logic [63:0] s, input logic [63:0] d);
        @(posedge clk);
        #1;
        init  = v;
        rot   = r;
        shift = s;
        data  = d;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        cyc    = 0;
        fin    = 1'b0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        init   = 1'b1;
        rot    = 1'b0;
        shift  = 64'h2;
        data   = rnd64();

        // Reset held with init_i high: nothing may come out.
        repeat (4) drive(1'b1, 1'($urandom_range(1)), 64'h1 << $urandom_range(63), rnd64());
        drive(1'b1, 1'b0, 64'h2, 64'h8000_0000_0000_0001);
        rst_n = 1'b1;

        // Directed cases.
        drive(1'b1, 1'b1, 64'h2, 64'h8000_0000_0000_0001);
        drive(1'b1, 1'b0, 64'h0, 64'hDEAD_BEEF_0123_4567);
        drive(1'b1, 1'b1, 64'h0, 64'hFEDC_BA98_7654_3210);
        drive(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h1);
        drive(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h3);
        drive(1'b1, 1'b0, 64'h9, 64'h1);
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);

        // Streaming every amount back to back, then a 3-cycle bubble with X inputs.
        for (int i = 0; i < 64; i++) drive(1'b1, 1'($urandom_range(1)), 64'h1 << i, rnd64());
        repeat (3) drive(1'b0, 1'bx, 64'hx, 64'hx);
        for (int i = 0; i < 40; i++)
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), rnd64() & rnd64(), rnd64());

        // Mid-flight reset pulse on the third op's cycle.
        drive(1'b1, 1'b0, 64'h10, rnd64());
        drive(1'b1, 1'b1, 64'h100, rnd64());
        drive(1'b1, 1'b1, 64'h4, rnd64());
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 64'h0, 64'h0);
        rst_n = 1'b1;
        repeat (8) drive(1'b0, 1'b0, 64'h0, 64'h0);

        for (int i = 0; i < 16; i++) drive(1'b1, 1'($urandom_range(1)), rnd64(), rnd64());
        repeat (12) drive(1'b0, 1'b0, 64'h0, 64'h0);
        fin = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
